// File: rtl/jam_pkg.sv
// Shared types and constants for the round-robin jam arbiter.
package jam_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } jam_state_e;

  // Lane-index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam jam_state_e RST_STATE   = IDLE;
  localparam logic       RST_VALID   = 1'b0;
  localparam logic       RST_ROTATED = 1'b0;

endpackage

// File: rtl/jam_rr_pick.sv
// Rotated-mask priority encoder: first requesting lane after cur, wrapping back to cur.
module jam_rr_pick
  import jam_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = idx_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [IDX_W-1:0]     cur,
  output logic                 found,
  output logic [IDX_W-1:0]     nxt
);

  logic [2*NUM_LANES-1:0] dbl;
  logic [NUM_LANES-1:0]   rmask;

  always_comb begin
    dbl   = {req, req};
    // bit i of rmask is lane (cur+1+i) mod NUM_LANES
    rmask = NUM_LANES'(dbl >> (32'(cur) + 32'd1));
    found = |rmask;
    nxt   = '0;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (rmask[i]) nxt = IDX_W'((int'(cur) + 1 + i) % NUM_LANES);
  end

endmodule

// File: rtl/jam_rr_arbiter.sv
// Round-robin jam arbiter with dwell-timer auto-rotation and early release.
// Optional JAM_MIN_GREEN_EN defers manual rotates until MIN_GREEN serve cycles have elapsed.
module jam_rr_arbiter
  import jam_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = idx_w(NUM_LANES),
  parameter int DWELL_W   = 8,
  parameter int MIN_GREEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] jam_req,
  input  logic                 jam_en,
  input  logic                 jam_start,
  input  logic                 jam_rotate,
  input  logic [DWELL_W-1:0]   dwell_cycles,
  output logic [NUM_LANES-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid,
  output logic                 rotated
);

  localparam logic [IDX_W-1:0]   LAST_LANE = IDX_W'(NUM_LANES-1);
  localparam logic [DWELL_W-1:0] MG_LAST   = DWELL_W'(MIN_GREEN-1);

  jam_state_e           state_q, state_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [NUM_LANES-1:0] grant_d;
  logic                 rot_d;
  logic                 scan_found, rr_found;
  logic [IDX_W-1:0]     scan_idx, rr_idx;
  logic                 auto_hit, man_hit, pend_q, pend_d, pend_set;

  // Lane-0 scan is the rotation search seeded from the last lane.
  jam_rr_pick #(.NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_scan (
    .req(jam_req), .cur(LAST_LANE), .found(scan_found), .nxt(scan_idx)
  );

  jam_rr_pick #(.NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_rr (
    .req(jam_req), .cur(cur_q), .found(rr_found), .nxt(rr_idx)
  );

  assign auto_hit = (dwell_cycles != '0) && (cnt_q == dwell_cycles - DWELL_W'(1));

`ifdef JAM_MIN_GREEN_EN
  assign man_hit  = (jam_rotate || pend_q) && (cnt_q >= MG_LAST);
  assign pend_set = jam_rotate && (cnt_q < MG_LAST);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
`else
  logic unused_mg;
  assign unused_mg = ^MG_LAST;
  assign man_hit   = jam_rotate;
  assign pend_set  = 1'b0;
  assign pend_q    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    rot_d   = 1'b0;
    pend_d  = pend_q;
    if (!jam_en) begin
      state_d = IDLE;
      cur_d   = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else if (jam_start) begin
      pend_d  = 1'b0;
      cnt_d   = '0;
      state_d = scan_found ? SERVE : IDLE;
      cur_d   = scan_found ? scan_idx : '0;
    end else if (state_q == SERVE) begin
      if (!jam_req[cur_q]) begin
        // served lane cleared: hand over, or go idle if nobody is jammed
        pend_d  = 1'b0;
        cnt_d   = '0;
        state_d = rr_found ? SERVE : IDLE;
        cur_d   = rr_found ? rr_idx : '0;
        rot_d   = rr_found;
      end else if (man_hit || auto_hit) begin
        pend_d = man_hit ? 1'b0 : (pend_q | pend_set);
        cnt_d  = '0;
        cur_d  = rr_idx;
        rot_d  = (rr_idx != cur_q);
      end else begin
        pend_d = pend_q | pend_set;
        if (cnt_q != '1) cnt_d = cnt_q + DWELL_W'(1);
      end
    end
    grant_d = '0;
    if (state_d == SERVE) grant_d[cur_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RST_STATE;
      cur_q   <= '0;
      cnt_q   <= '0;
      grant   <= '0;
      rotated <= RST_ROTATED;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      grant   <= grant_d;
      rotated <= rot_d;
    end

  assign grant_idx   = cur_q;
  assign grant_valid = (state_q == SERVE) ? 1'b1 : RST_VALID;

endmodule

// File: tb/tb_jam_rr_arbiter.sv
// Self-checking bench for jam_rr_arbiter: directed literal checks plus randomized traffic against a lane-level model.
module tb_jam_rr_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 8;
  localparam int MG = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]  jam_req = '0;
  logic          jam_en = 1'b0, jam_start = 1'b0, jam_rotate = 1'b0;
  logic [DW-1:0] dwell_cycles = '0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid, rotated;

  int n_chk = 0, n_fail = 0;

  jam_rr_arbiter #(.NUM_LANES(N), .IDX_W(IW), .DWELL_W(DW), .MIN_GREEN(MG)) dut (
    .clk(clk), .rst_n(rst_n), .jam_req(jam_req), .jam_en(jam_en),
    .jam_start(jam_start), .jam_rotate(jam_rotate), .dwell_cycles(dwell_cycles),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .rotated(rotated)
  );

  always #5 clk = ~clk;

  // Lane-level model: whether a lane is served, which one, cycles served, deferred rotate.
  bit m_on, m_rot, m_pend;
  int m_lane, m_cnt;

  function automatic int next_req(input int from);
    for (int s = 1; s <= N; s++) if (jam_req[(from + s) % N]) return (from + s) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on = 0; m_rot = 0; m_pend = 0; m_lane = 0; m_cnt = 0;
    end else begin
      int t;
      bit man, auto_r;
      m_rot = 0;
`ifdef JAM_MIN_GREEN_EN
      man = (jam_rotate || m_pend) && (m_cnt >= MG - 1);
`else
      man = jam_rotate;
`endif
      auto_r = (dwell_cycles != 0) && (m_cnt == int'(dwell_cycles) - 1);
      if (!jam_en) begin
        m_on = 0; m_lane = 0; m_cnt = 0; m_pend = 0;
      end else if (jam_start) begin
        t = next_req(N - 1);
        m_on = (t >= 0); m_lane = (t >= 0) ? t : 0; m_cnt = 0; m_pend = 0;
      end else if (m_on) begin
        t = next_req(m_lane);
        if (!jam_req[m_lane]) begin
          m_pend = 0; m_cnt = 0;
          if (t < 0) begin m_on = 0; m_lane = 0; end
          else begin m_rot = 1; m_lane = t; end
        end else if (man || auto_r) begin
          if (man) m_pend = 0;
`ifdef JAM_MIN_GREEN_EN
          else if (jam_rotate && m_cnt < MG - 1) m_pend = 1;
`endif
          m_cnt = 0;
          if (t != m_lane) begin m_rot = 1; m_lane = t; end
        end else begin
`ifdef JAM_MIN_GREEN_EN
          if (jam_rotate && m_cnt < MG - 1) m_pend = 1;
`endif
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end
    end
  end

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clk) if (rst_n) begin
    logic [N-1:0] eg;
    logic [IW-1:0] ei;
    eg = m_on ? (N'(1) << m_lane) : '0;
    ei = m_on ? IW'(m_lane) : '0;
    n_chk++;
    if ({grant, grant_idx, grant_valid, rotated} !== {eg, ei, m_on, m_rot}) begin
      n_fail++;
      $display("FAIL model t=%0t grant=%b idx=%0d valid=%b rot=%b required grant=%b idx=%0d valid=%b rot=%b",
               $time, grant, grant_idx, grant_valid, rotated, eg, ei, m_on, m_rot);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic lit(input string nm, input logic [N-1:0] eg, input int ei, input bit ev, input bit er);
    n_chk++;
    if (grant !== eg || grant_idx !== IW'(ei) || grant_valid !== ev || rotated !== er) begin
      n_fail++;
      $display("FAIL %s grant=%b idx=%0d valid=%b rot=%b required grant=%b idx=%0d valid=%b rot=%b",
               nm, grant, grant_idx, grant_valid, rotated, eg, ei, ev, er);
    end
  endtask

  task automatic start_with(input logic [N-1:0] r);
    jam_req = r; jam_start = 1'b1; step(); jam_start = 1'b0;
  endtask

  initial begin
    step(); step();
    lit("reset", 4'b0000, 0, 0, 0);
    rst_n = 1'b1; jam_en = 1'b1;
    start_with(4'b0110);
    lit("start_lowest", 4'b0010, 1, 1, 0);

    jam_req = 4'b1010; jam_rotate = 1'b1; step(); jam_rotate = 1'b0;
    lit("rotate_1_to_3", 4'b1000, 3, 1, 1);
    step();
    lit("rotate_pulse_end", 4'b1000, 3, 1, 0);
    jam_rotate = 1'b1; step(); jam_rotate = 1'b0;
    lit("rotate_wrap", 4'b0010, 1, 1, 1);

    dwell_cycles = 8'd5;
    start_with(4'b0101);
    lit("dwell_first", 4'b0001, 0, 1, 0);
    for (int k = 1; k < 20; k++) begin
      int el;
      step();
      el = ((k / 5) % 2) ? 2 : 0;
      lit($sformatf("dwell_k%0d", k), N'(1) << el, el, 1, (k % 5) == 0);
    end

    dwell_cycles = 8'd0;
    start_with(4'b0101);
    repeat (12) step();
    lit("dwell_zero_hold", 4'b0001, 0, 1, 0);

    start_with(4'b0100);
    jam_req = 4'b0000; step();
    lit("release_idle", 4'b0000, 0, 0, 0);
    start_with(4'b0100);
    jam_req = 4'b1000; step();
    lit("release_move", 4'b1000, 3, 1, 1);

    jam_en = 1'b0; step();
    lit("en_low", 4'b0000, 0, 0, 0);
    jam_en = 1'b1; step();
    lit("idle_no_start", 4'b0000, 0, 0, 0);

    start_with(4'b0110);
    lit("pre_async", 4'b0010, 1, 1, 0);
    @(posedge clk); #3; rst_n = 1'b0; #1;
    lit("async_reset", 4'b0000, 0, 0, 0);
    step(); rst_n = 1'b1;

    start_with(4'b0110);
    jam_start = 1'b1; jam_rotate = 1'b1; step(); jam_start = 1'b0; jam_rotate = 1'b0;
    lit("start_beats_rotate", 4'b0010, 1, 1, 0);

    start_with(4'b0101);
    step();
    jam_rotate = 1'b1; step(); jam_rotate = 1'b0;
`ifdef JAM_MIN_GREEN_EN
    lit("mg_defer_a", 4'b0001, 0, 1, 0);
    step();
    lit("mg_defer_b", 4'b0001, 0, 1, 0);
    step();
    lit("mg_exec", 4'b0100, 2, 1, 1);
`else
    lit("rotate_immediate", 4'b0100, 2, 1, 1);
`endif

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) < 3) rst_n = 1'b0;
      else rst_n = 1'b1;
      jam_en     = ($urandom_range(0, 99) < 93);
      jam_start  = ($urandom_range(0, 99) < 6);
      jam_rotate = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 20) jam_req = N'($urandom);
      if ($urandom_range(0, 99) < 3)  dwell_cycles = DW'($urandom_range(0, 7));
      step();
    end
    rst_n = 1'b1; jam_start = 1'b0; jam_rotate = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jam_rr_arbiter.md
Name: jam_rr_arbiter

Overview:
- Parametrised round-robin arbiter granting one jammed lane at a time at the traffic junction.
- Generalises the 4-lane jam opportunity logic to NUM_LANES lanes.
- Adds a programmable dwell timer for automatic rotation, early release when the served lane clears, and a grant-index/valid interface.
- Sits between the per-lane jam detectors and the light-phase controller.

Parameters:
- NUM_LANES, 4, number of lanes arbitrated (2..16).
- IDX_W, $clog2(NUM_LANES), width of lane index.
- DWELL_W, 8, width of dwell counter and dwell_cycles input.
- MIN_GREEN, 4, minimum serve cycles before a manual rotate is honoured (used only with optional feature).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- jam_req  input  NUM_LANES  per-lane traffic-jam flags, level.
- jam_en  input  1  arbiter enable; low forces idle.
- jam_start  input  1  pulse, begin service from lane 0 priority scan.
- jam_rotate  input  1  pulse, move grant to next requesting lane.
- dwell_cycles  input  DWELL_W  auto-rotate period in cycles; 0 disables auto-rotate.
- grant  output  NUM_LANES  one-hot allow vector (all zero when idle).
- grant_idx  output  IDX_W  index of granted lane; 0 when idle.
- grant_valid  output  1  high while any lane is granted.
- rotated  output  1  one-cycle pulse when grant changes lane via rotation or early release.

Behaviour:
- Reset: grant=0, grant_idx=0, grant_valid=0, rotated=0, state=IDLE, dwell counter=0. All outputs registered.
- States: IDLE, SERVE.
- Priority of events in one cycle: jam_en low > jam_start > early release > jam_rotate/auto-rotate.
- jam_en low, any state: next cycle IDLE, all outputs cleared, counter 0.
- IDLE + jam_start + |jam_req: grant the lowest-index requesting lane next cycle; enter SERVE; counter=0; rotated=0.
- IDLE + jam_start + no requests: remain IDLE.
- IDLE without jam_start: remain IDLE regardless of jam_req.
- SERVE + jam_start: re-scan from lane 0, as in IDLE; counter cleared.
- Rotation target: first requesting lane scanning cur+1, cur+2, ... with wrap modulo NUM_LANES, ending at cur itself.
  - Target == cur: grant held, counter cleared, rotated=0.
  - Target differs: grant moves, counter cleared, rotated=1 for one cycle.
- Rotation triggers (SERVE):
  - jam_rotate pulse.
  - Auto-rotate when dwell_cycles!=0 and counter==dwell_cycles-1.
  - Simultaneous manual and auto triggers produce a single rotation.
- Early release: in SERVE, if jam_req[cur]==0, perform rotation next cycle. If no lane requests, go to IDLE with outputs cleared and rotated=0.
- Dwell counter: increments each SERVE cycle; saturates at all-ones; cleared on any grant change, hold, or start.
- dwell_cycles changed mid-serve: new value takes effect immediately. If counter already ≥ new value-1, no auto-rotate fires until the next clear.
- Latency: one cycle from sampled input to grant update.
- Reset asserted mid-serve: immediate clear, independent of clk.

Optional Feature:
- Macro: JAM_MIN_GREEN_EN.
- Defined:
  - jam_rotate received while counter < MIN_GREEN-1 is latched as pending and executed at the cycle counter reaches MIN_GREEN-1.
  - Pending is cleared by that execution, jam_start, early release, or jam_en low.
  - Auto-rotate is unaffected.
- Undefined: jam_rotate is acted on immediately; no pending register exists.

Decomposition:
- Package jam_pkg holds:
  - state enum (IDLE, SERVE);
  - the lane-index width function;
  - reset constants.
- One combinational sub-module, jam_rr_pick. It takes jam_req and the current index and returns found plus next index, using a rotated-mask priority encoder. Instantiated once for rotation; the lane-0 scan uses it with cur=NUM_LANES-1.

Test Plan:
- Reset then jam_en=1, jam_req=4'b0110, jam_start -> next cycle grant=0010, grant_idx=1, grant_valid=1, rotated=0.
- In SERVE on lane 1 with jam_req=1010, pulse jam_rotate -> grant=1000, idx=3, rotated=1. Rotate again -> grant=0010 (wrap).
- dwell_cycles=5, jam_req=0101, start -> lane 0 for 5 cycles, then lane 2 for 5 cycles, alternating. With dwell_cycles=0, lane 0 is held indefinitely.
- Serving lane 2 with jam_req=0100, drop jam_req to 0000 -> next cycle IDLE, grant=0, valid=0. With jam_req=1000 instead -> grant=1000, rotated=1.
- jam_en low mid-serve, and separately rst_n low mid-cycle -> outputs 0 (async for rst_n). jam_start and jam_rotate in the same cycle -> lane-0 scan result.
- With JAM_MIN_GREEN_EN and MIN_GREEN=4: rotate at serve cycle 1 -> grant changes at counter==3, not before. Without the macro -> changes the next cycle.
